// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-path definitions.
// Data width and capture-FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [0:0] {
    RXF_IDLE  = 1'b0,
    RXF_CLEAR = 1'b1
  } rxf_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and read-side signals of uart_rx_fifo.
// slave = FIFO side, master = receiver/consumer side.
// Ports: rx_rdy, rx_data, rdy_clear (receiver);
//   rd_en, rd_data, empty, full, count (read port);
//   overrun, ovr_clear only with UART_RX_FIFO_OVERRUN_EN.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                   rx_rdy;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rdy_clear;
  logic                   rd_en;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   empty;
  logic                   full;
  logic [ADDR_W:0]        count;
`ifdef UART_RX_FIFO_OVERRUN_EN
  logic                   overrun;
  logic                   ovr_clear;

  modport slave (
    input  rx_rdy, rx_data, rd_en, ovr_clear,
    output rdy_clear, rd_data, empty, full,
    output count, overrun
  );

  modport master (
    output rx_rdy, rx_data, rd_en, ovr_clear,
    input  rdy_clear, rd_data, empty, full,
    input  count, overrun
  );
`else
  modport slave (
    input  rx_rdy, rx_data, rd_en,
    output rdy_clear, rd_data, empty, full,
    output count
  );

  modport master (
    output rx_rdy, rx_data, rd_en,
    input  rdy_clear, rd_data, empty, full,
    input  count
  );
`endif

endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x 8 register array, no reset.
// Ports: clk, i_we/i_waddr/i_wdata (sync write),
//   i_raddr/o_rdata (async read).
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_waddr,
  input  logic [UART_DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]      i_raddr,
  output logic [UART_DATA_W-1:0] o_rdata
);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures receiver bytes into a FWFT FIFO.
// Ports: clk, rst (async, active-low), io_fifo (slave).
// Optional drop-on-full with sticky overrun flag:
//   define UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  io_fifo
);

  localparam logic [0:0] S_IDLE  = RXF_IDLE;
  localparam logic [0:0] S_CLEAR = RXF_CLEAR;

  localparam logic [ADDR_W:0] L_FULL =
    (ADDR_W+1)'(DEPTH);

  logic [0:0]             r_state;
  logic                   r_rdy_clear;
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_count;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_req;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_go;
  logic [UART_DATA_W-1:0] w_rdata;

  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);
  assign w_req   = (r_state == S_IDLE) &&
                   io_fifo.rx_rdy;
  assign w_wr    = w_req && !w_full;
  assign w_rd    = io_fifo.rd_en && !w_empty;

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic w_drop;
  logic r_overrun;

  // Full: byte is dropped but the receiver
  // is still released.
  assign w_drop = w_req && w_full;
  assign w_go   = w_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (io_fifo.ovr_clear) begin
      r_overrun <= 1'b0;
    end
  end

  assign io_fifo.overrun = r_overrun;
`else
  // Full: leave the byte in the receiver
  // and retry once space frees up.
  assign w_go = w_wr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rdy_clear <= 1'b0;
    end else begin
      r_rdy_clear <= w_go;
      case (r_state)
        S_IDLE: begin
          if (w_go) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          // Wait for rdy to fall so one frame
          // is never captured twice.
          if (!io_fifo.rx_rdy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (io_fifo.rx_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign io_fifo.rdy_clear = r_rdy_clear;
  assign io_fifo.rd_data   = w_empty ? '0 : w_rdata;
  assign io_fifo.empty     = w_empty;
  assign io_fifo.full      = w_full;
  assign io_fifo.count     = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
// Overrun checks apply when UART_RX_FIFO_OVERRUN_EN is defined.
module tb_uart_rx_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pulses;

  uart_rx_fifo_if #(.DEPTH(16)) u_if ();

  uart_rx_fifo #(
    .DEPTH (16)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .io_fifo (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    u_if.rx_rdy  = 1'b1;
    u_if.rx_data = b;
    step();
    chk("push_clr", 32'(u_if.rdy_clear), 1);
    u_if.rx_rdy = 1'b0;
    step();
  endtask

  task automatic pop_chk(input string tag,
                         input logic [7:0] exp);
    chk(tag, 32'(u_if.rd_data), 32'(exp));
    u_if.rd_en = 1'b1;
    step();
    u_if.rd_en = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    u_if.rx_rdy  = 1'b0;
    u_if.rx_data = 8'h00;
    u_if.rd_en   = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
    u_if.ovr_clear = 1'b0;
`endif
    step();
    step();
    chk("rst_clr",   32'(u_if.rdy_clear), 0);
    chk("rst_empty", 32'(u_if.empty), 1);
    chk("rst_full",  32'(u_if.full), 0);
    chk("rst_count", 32'(u_if.count), 0);
    chk("rst_data",  32'(u_if.rd_data), 0);
`ifdef UART_RX_FIFO_OVERRUN_EN
    chk("rst_ovr",   32'(u_if.overrun), 0);
`endif
    rst = 1'b1;
    step();

    // single byte held for 3 cycles
    u_if.rx_rdy  = 1'b1;
    u_if.rx_data = 8'hA5;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (u_if.rdy_clear) pulses++;
    end
    chk("sb_pulses", 32'(pulses), 1);
    chk("sb_count",  32'(u_if.count), 1);
    chk("sb_data",   32'(u_if.rd_data), 32'h A5);
    chk("sb_empty",  32'(u_if.empty), 0);
    u_if.rx_rdy = 1'b0;
    step();
    pop_chk("sb_pop", 8'hA5);
    chk("sb_empty2", 32'(u_if.empty), 1);
    chk("sb_data0",  32'(u_if.rd_data), 0);
    chk("sb_count0", 32'(u_if.count), 0);

    // fill and wrap
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fw_full",  32'(u_if.full), 1);
    chk("fw_count", 32'(u_if.count), 16);
    for (int i = 0; i < 4; i++) pop_chk("fw_pop", 8'(i));
    chk("fw_c12", 32'(u_if.count), 12);
    chk("fw_nf",  32'(u_if.full), 0);
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    chk("fw_full2", 32'(u_if.full), 1);
    for (int i = 0; i < 16; i++) begin
      chk("fw_cnt", 32'(u_if.count), 32'(16 - i));
      pop_chk("fw_ord", 8'(8'h04 + i));
    end
    chk("fw_empty", 32'(u_if.empty), 1);
    chk("fw_c0",    32'(u_if.count), 0);

    // simultaneous read and write at count 5
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    u_if.rx_rdy  = 1'b1;
    u_if.rx_data = 8'h25;
    u_if.rd_en   = 1'b1;
    step();
    u_if.rd_en  = 1'b0;
    u_if.rx_rdy = 1'b0;
    chk("sim_count", 32'(u_if.count), 5);
    chk("sim_clr",   32'(u_if.rdy_clear), 1);
    chk("sim_head",  32'(u_if.rd_data), 32'h21);
    step();
    for (int i = 0; i < 5; i++)
      pop_chk("sim_ord", 8'(8'h21 + i));
    chk("sim_empty", 32'(u_if.empty), 1);

    // full-case behaviour
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    chk("fc_full", 32'(u_if.full), 1);
`ifdef UART_RX_FIFO_OVERRUN_EN
    u_if.rx_rdy  = 1'b1;
    u_if.rx_data = 8'h77;
    step();
    chk("ov_clr",   32'(u_if.rdy_clear), 1);
    chk("ov_count", 32'(u_if.count), 16);
    chk("ov_flag",  32'(u_if.overrun), 1);
    step();
    chk("ov_clr0",  32'(u_if.rdy_clear), 0);
    u_if.rx_rdy = 1'b0;
    step();
    // drop and clear in the same cycle: set wins
    u_if.rx_rdy    = 1'b1;
    u_if.rx_data   = 8'h66;
    u_if.ovr_clear = 1'b1;
    step();
    chk("ov_setwin", 32'(u_if.overrun), 1);
    u_if.rx_rdy    = 1'b0;
    u_if.ovr_clear = 1'b0;
    step();
    u_if.ovr_clear = 1'b1;
    step();
    u_if.ovr_clear = 1'b0;
    chk("ov_cleared", 32'(u_if.overrun), 0);
    // write and read while full
    u_if.rx_rdy  = 1'b1;
    u_if.rx_data = 8'h88;
    u_if.rd_en   = 1'b1;
    step();
    u_if.rd_en  = 1'b0;
    u_if.rx_rdy = 1'b0;
    chk("ovs_count", 32'(u_if.count), 15);
    chk("ovs_flag",  32'(u_if.overrun), 1);
    chk("ovs_clr",   32'(u_if.rdy_clear), 1);
    step();
    for (int i = 0; i < 15; i++)
      pop_chk("ov_ord", 8'(8'h31 + i));
    chk("ov_empty", 32'(u_if.empty), 1);
`else
    u_if.rx_rdy  = 1'b1;
    u_if.rx_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fc_noclr", 32'(u_if.rdy_clear), 0);
      chk("fc_cnt16", 32'(u_if.count), 16);
    end
    // pop while full: write side still sees full
    u_if.rd_en = 1'b1;
    step();
    u_if.rd_en = 1'b0;
    chk("fc_c15",   32'(u_if.count), 15);
    chk("fc_clr0",  32'(u_if.rdy_clear), 0);
    chk("fc_head",  32'(u_if.rd_data), 32'h31);
    step();
    chk("fc_cap",   32'(u_if.count), 16);
    chk("fc_clr1",  32'(u_if.rdy_clear), 1);
    u_if.rx_rdy = 1'b0;
    step();
    for (int i = 0; i < 15; i++)
      pop_chk("fc_ord", 8'(8'h31 + i));
    pop_chk("fc_last", 8'h77);
    chk("fc_empty", 32'(u_if.empty), 1);
`endif

    // reset mid-operation with rdy still high
    push(8'h41);
    push(8'h42);
    u_if.rx_rdy  = 1'b1;
    u_if.rx_data = 8'h55;
    #2;
    rst = 1'b0;
    #1;
    chk("mr_count", 32'(u_if.count), 0);
    chk("mr_empty", 32'(u_if.empty), 1);
    chk("mr_full",  32'(u_if.full), 0);
    chk("mr_clr",   32'(u_if.rdy_clear), 0);
    chk("mr_data",  32'(u_if.rd_data), 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mr_cap",   32'(u_if.count), 1);
    chk("mr_clr1",  32'(u_if.rdy_clear), 1);
    chk("mr_byte",  32'(u_if.rd_data), 32'h55);
    u_if.rx_rdy = 1'b0;
    step();
    pop_chk("mr_pop", 8'h55);
    chk("mr_empty2", 32'(u_if.empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART Receiver. It watches the receiver's `rdy`/`data_out` pair and copies each completed byte into a power-of-two FIFO. It then pulses the receiver's `rdy_clear` to free it for the next frame. Software or a consumer block drains bytes through a first-word-fall-through read port, so several frames can arrive before the host must respond.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two, minimum 2.
- `ADDR_W`, $clog2(DEPTH): pointer width. Derived; never overridden.
- `clk` input 1: single clock, shared with the receiver and the baud generator.
- `rst` input 1: reset, asynchronous assert, active-low. The clock is `clk` and the reset is `rst`; polarity and synchronicity are fixed.
- `rx_rdy` input 1: receiver `rdy`, a level that stays high until cleared.
- `rx_data` input 8: receiver `data_out`, stable while `rx_rdy` is high.
- `rdy_clear` output 1: drives the receiver `rdy_clear`. Registered single-cycle pulse.
- `rd_en` input 1: pop request. Ignored when `empty`.
- `rd_data` output 8: head entry. Reads 8'h00 when `empty`.
- `empty` output 1: FIFO holds 0 entries.
- `full` output 1: FIFO holds `DEPTH` entries.
- `count` output ADDR_W+1: occupancy, 0..DEPTH.
- `overrun` output 1: sticky drop flag. Present only with `UART_RX_FIFO_OVERRUN_EN`.
- `ovr_clear` input 1: clears `overrun`. Present only with `UART_RX_FIFO_OVERRUN_EN`.

## Operation
- Capture FSM has two states, IDLE and CLEAR.
- **IDLE with `rx_rdy`=1 and the FIFO not full:**
  - write `rx_data` at `wr_ptr` and increment `wr_ptr`;
  - set `rdy_clear` to 1 for the next cycle;
  - go to CLEAR.
- **IDLE with `rx_rdy`=1 and `full`=1:** behaviour set by the build configuration (see Configuration).
- **CLEAR:** `rdy_clear` returns to 0. Stay in CLEAR while `rx_rdy`=1 and return to IDLE once `rx_rdy`=0. This prevents one frame being captured twice while the receiver's `rdy` falls.
- **Read:** `rd_en`=1 and not `empty` increments `rd_ptr`. `rd_data` is asynchronous from `mem[rd_ptr]`, gated to 0 when empty.
- **Pointers:** `ADDR_W`-bit, wrap naturally modulo `DEPTH`. `count` is a separate register: +1 on write only, −1 on read only, unchanged when both happen.
- **Flags:** `full` = (`count`==DEPTH); `empty` = (`count`==0). Both are decoded from the registered `count`.
- **Simultaneous write and read:**
  - not empty and not full: both happen, `count` unchanged.
  - full: the write-side decision uses the pre-edge `full`, so the FIFO is treated as full. The read pops; the write is handled as in the full case.
  - empty: the read is ignored; the write happens.
- **Reset mid-frame:** all state is lost and the FSM returns to IDLE. A receiver `rdy` still high after reset is captured normally.

## Timing
- **Reset values:**
  - `rdy_clear`=0, `empty`=1, `full`=0, `count`=0, `rd_data`=0, `overrun`=0;
  - FSM in IDLE, pointers 0.
  - Memory contents are not reset.
- **Capture latency:** `rx_rdy` sampled high at edge N in IDLE means the write and `count`+1 happen at edge N. After N, `empty` falls and the byte appears on `rd_data`. `rdy_clear` is high for cycle N..N+1.
- **Pop latency:** `rd_en` at edge M means the next entry (or 0 if now empty) appears on `rd_data` after M.
- **Throughput:** one byte per `rx_rdy` rise, at most one per 2 cycles. This far exceeds the UART frame rate.

## Configuration
- `UART_RX_FIFO_OVERRUN_EN` defined:
  - with `full`=1 in IDLE and `rx_rdy`=1, the byte is dropped;
  - `rdy_clear` still pulses and the FSM goes to CLEAR;
  - `overrun` is set to 1 and stays high until `ovr_clear`=1 at an edge;
  - if set and clear happen in the same cycle, set wins.
- `UART_RX_FIFO_OVERRUN_EN` undefined:
  - `overrun` and `ovr_clear` are absent;
  - with `full`=1 the FSM stays in IDLE without pulsing `rdy_clear`, leaving the byte in the receiver;
  - capture proceeds the edge after `full` drops.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W` = 8;
  - the capture-state enum (`RXF_IDLE`, `RXF_CLEAR`).
- One sub-module, `uart_fifo_mem`: `DEPTH`×8 register array with one synchronous write port and one asynchronous read port, no reset.
- Pointers, `count`, the FSM and the overrun logic live in `uart_rx_fifo`.

## Test plan
- **Reset:** assert `rst`=0 mid-operation, then release. Expect all outputs at their reset values and the FSM in IDLE.
- **Single byte:** hold `rx_rdy`=1 with `rx_data`=8'hA5 for 3 cycles. Expect one `rdy_clear` pulse, `count`=1, `rd_data`=8'hA5, no second write. Pulse `rd_en`: expect `empty`=1 and `rd_data`=0.
- **Fill and wrap:** 16 frames 8'h00..8'h0F give `full`=1. Pop 4, push 8'h10..8'h13, pop all. Expect the order 04..13 with `count` tracking exactly.
- **Simultaneous read and write:**
  - at `count`=5: `count` stays 5 and order is preserved;
  - at full: the pop happens and the incoming byte follows the full-case rule.
- **Full without `UART_RX_FIFO_OVERRUN_EN`:** at `count`=16, `rx_rdy`=1 with 8'h77. Expect no `rdy_clear` until one pop. Then capture, with 8'h77 last out.
- **Full with `UART_RX_FIFO_OVERRUN_EN`:** the same stimulus gives a `rdy_clear` pulse, 8'h77 dropped, `count`=16, `overrun`=1. `ovr_clear` returns `overrun` to 0.
